// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the memory-stage sequencer.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [3:0]  lc3b_opcode;

  localparam lc3b_opcode OP_LDB = 4'b0010;
  localparam lc3b_opcode OP_STB = 4'b0011;
  localparam lc3b_opcode OP_LDR = 4'b0110;
  localparam lc3b_opcode OP_STR = 4'b0111;
  localparam lc3b_opcode OP_LDI = 4'b1010;
  localparam lc3b_opcode OP_STI = 4'b1011;

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} mem_state_t;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  function automatic logic is_indirect(input lc3b_opcode op);
    return (op == OP_LDI) || (op == OP_STI);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_byte_lane.sv
// Byte-lane steering: replicate/mask for byte stores, extract/zero-extend for byte loads.
module mem_byte_lane
  import lc3b_types::*;
(
  input  logic       st_addr_lsb,
  input  lc3b_word   st_wdata,
  output lc3b_word   st_wdata_rep,
  output logic [1:0] st_be,
  input  logic       ld_addr_lsb,
  input  lc3b_word   ld_rdata,
  output lc3b_word   ld_byte
);

  assign st_wdata_rep = {st_wdata[7:0], st_wdata[7:0]};
  assign st_be        = st_addr_lsb ? BE_HI : BE_LO;
  assign ld_byte      = {8'h00, (ld_addr_lsb ? ld_rdata[15:8] : ld_rdata[7:0])};

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: single and indirect (LDI/STI) data-cache accesses with pipeline stall.
module mem_access_ctrl
  import lc3b_types::*;
#(
  parameter int WORD_WIDTH   = 16,
  parameter int RESP_TIMEOUT = 0
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic [3:0]            opcode,
  input  logic                  read_memory,
  input  logic                  write_memory,
  input  logic                  byte_op,
  input  logic [WORD_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] wdata,
  input  logic                  dmem_resp,
  input  logic [WORD_WIDTH-1:0] dmem_rdata,
  output logic                  dmem_read,
  output logic                  dmem_write,
  output logic [WORD_WIDTH-1:0] dmem_address,
  output logic [WORD_WIDTH-1:0] dmem_wdata,
  output logic [1:0]            dmem_byte_enable,
  output logic                  stall,
  output logic [WORD_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  mem_error
);

  localparam bit         TO_EN   = (RESP_TIMEOUT > 0);
  localparam logic [15:0] TO_LAST = 16'(RESP_TIMEOUT - 1);

  logic        req;
  mem_state_t  state_q, state_d;
  lc3b_opcode  op_q, op_d;
  lc3b_word    addr_q, addr_d, wdata_q, wdata_d;
  logic        byte_q, byte_d, rd_q, rd_d;
  logic [15:0] cnt_q, cnt_d;
  logic        dmem_read_q, dmem_read_d, dmem_write_q, dmem_write_d;
  lc3b_word    dmem_address_q, dmem_address_d, dmem_wdata_q, dmem_wdata_d;
  logic [1:0]  dmem_be_q, dmem_be_d;
  lc3b_word    rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d, mem_error_q, mem_error_d;
  lc3b_word    st_wdata_rep, ld_byte;
  logic [1:0]  st_be;

  assign req = valid & (read_memory | write_memory);

  mem_byte_lane u_lane (
    .st_addr_lsb  (addr[0]),
    .st_wdata     (wdata),
    .st_wdata_rep (st_wdata_rep),
    .st_be        (st_be),
    .ld_addr_lsb  (addr_q[0]),
    .ld_rdata     (dmem_rdata),
    .ld_byte      (ld_byte)
  );

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    byte_d         = byte_q;
    rd_d           = rd_q;
    cnt_d          = cnt_q;
    dmem_read_d    = dmem_read_q;
    dmem_write_d   = dmem_write_q;
    dmem_address_d = dmem_address_q;
    dmem_wdata_d   = dmem_wdata_q;
    dmem_be_d      = dmem_be_q;
    rdata_d        = rdata_q;
    rdata_valid_d  = 1'b0;
    mem_error_d    = mem_error_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d        = ACC1;
          op_d           = opcode;
          addr_d         = addr;
          wdata_d        = wdata;
          byte_d         = byte_op;
          rd_d           = read_memory;
          cnt_d          = '0;
          dmem_address_d = {addr[15:1], 1'b0};
          dmem_wdata_d   = '0;
          dmem_be_d      = 2'b00;
          // Indirect stores still read the pointer first.
          if (read_memory || is_indirect(opcode)) begin
            dmem_read_d = 1'b1;
          end else begin
            dmem_write_d = 1'b1;
            dmem_wdata_d = byte_op ? st_wdata_rep : wdata;
            dmem_be_d    = byte_op ? st_be : BE_WORD;
          end
        end
      end

      ACC1, ACC2: begin
        if (dmem_resp) begin
          if (state_q == ACC1 && is_indirect(op_q)) begin
            state_d        = ACC2;
            cnt_d          = '0;
            dmem_address_d = {dmem_rdata[15:1], 1'b0};
            dmem_read_d    = rd_q;
            dmem_write_d   = !rd_q;
            dmem_wdata_d   = rd_q ? 16'h0000 : wdata_q;
            dmem_be_d      = rd_q ? 2'b00 : BE_WORD;
          end else begin
            state_d        = DONE;
            dmem_read_d    = 1'b0;
            dmem_write_d   = 1'b0;
            dmem_address_d = '0;
            dmem_wdata_d   = '0;
            dmem_be_d      = 2'b00;
            if (rd_q) begin
              rdata_d       = byte_q ? ld_byte : dmem_rdata;
              rdata_valid_d = 1'b1;
            end
          end
        end else if (TO_EN && cnt_q == TO_LAST) begin
          state_d        = DONE;
          dmem_read_d    = 1'b0;
          dmem_write_d   = 1'b0;
          dmem_address_d = '0;
          dmem_wdata_d   = '0;
          dmem_be_d      = 2'b00;
          mem_error_d    = 1'b1;
          rdata_d        = 16'h0000;
          rdata_valid_d  = rd_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      op_q           <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      byte_q         <= 1'b0;
      rd_q           <= 1'b0;
      cnt_q          <= '0;
      dmem_read_q    <= 1'b0;
      dmem_write_q   <= 1'b0;
      dmem_address_q <= '0;
      dmem_wdata_q   <= '0;
      dmem_be_q      <= 2'b00;
      rdata_q        <= '0;
      rdata_valid_q  <= 1'b0;
      mem_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      byte_q         <= byte_d;
      rd_q           <= rd_d;
      cnt_q          <= cnt_d;
      dmem_read_q    <= dmem_read_d;
      dmem_write_q   <= dmem_write_d;
      dmem_address_q <= dmem_address_d;
      dmem_wdata_q   <= dmem_wdata_d;
      dmem_be_q      <= dmem_be_d;
      rdata_q        <= rdata_d;
      rdata_valid_q  <= rdata_valid_d;
      mem_error_q    <= mem_error_d;
    end
  end

  // IDLE stall is combinational so the requesting instruction freezes in its first cycle.
  assign stall = (state_q == ACC1) || (state_q == ACC2) ||
                 ((state_q == IDLE) && req && rst_n);

  assign dmem_read        = dmem_read_q;
  assign dmem_write       = dmem_write_q;
  assign dmem_address     = dmem_address_q;
  assign dmem_wdata       = dmem_wdata_q;
  assign dmem_byte_enable = dmem_be_q;
  assign rdata            = rdata_q;
  assign rdata_valid      = rdata_valid_q;
  assign mem_error        = mem_error_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a word-array memory model.
module tb_mem_access_ctrl;

  localparam int TO = 4;
  localparam logic [3:0] LDB = 4'b0010, STB = 4'b0011, LDR = 4'b0110,
                         STR = 4'b0111, LDI = 4'b1010, STI = 4'b1011;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        valid = 1'b0, read_memory = 1'b0, write_memory = 1'b0, byte_op = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic [15:0] addr = 16'h0, wdata = 16'h0, dmem_rdata = 16'h0;
  logic        dmem_resp = 1'b0;
  logic        dmem_read, dmem_write, stall, rdata_valid, mem_error;
  logic [15:0] dmem_address, dmem_wdata, rdata;
  logic [1:0]  dmem_byte_enable;

  always #5 clk = ~clk;

  mem_access_ctrl #(.WORD_WIDTH(16), .RESP_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .opcode(opcode),
    .read_memory(read_memory), .write_memory(write_memory), .byte_op(byte_op),
    .addr(addr), .wdata(wdata), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable), .stall(stall),
    .rdata(rdata), .rdata_valid(rdata_valid), .mem_error(mem_error)
  );

  logic [15:0] mem [0:32767];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] last_rdata = 16'h0;
  logic        err_exp = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // lat < 0 means that access never gets a response.
  task automatic run_txn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] w,
                         input int lat0, input int lat1);
    logic [15:0] ea [2];
    logic        ew [2];
    logic [1:0]  ebe [2];
    logic [15:0] ewd [2];
    int          lat [2];
    int          nacc, k, c, stalls, exp_stalls;
    logic        is_rd, timed_out, done;
    logic [15:0] ptr, word, res, old;

    is_rd = (op == LDR) || (op == LDB) || (op == LDI);
    nacc  = (op == LDI || op == STI) ? 2 : 1;
    lat[0] = lat0;
    lat[1] = lat1;
    ea[0]  = {a[15:1], 1'b0};
    ew[0]  = (op == STR) || (op == STB);
    ebe[0] = (op == STB) ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
    ewd[0] = (op == STB) ? {w[7:0], w[7:0]} : w;
    ptr    = mem[a[15:1]];
    ea[1]  = {ptr[15:1], 1'b0};
    ew[1]  = (op == STI);
    ebe[1] = 2'b11;
    ewd[1] = w;
    word   = mem[a[15:1]];
    case (op)
      LDR:     res = word;
      LDB:     res = a[0] ? {8'h00, word[15:8]} : {8'h00, word[7:0]};
      LDI:     res = mem[ptr[15:1]];
      default: res = last_rdata;
    endcase
    exp_stalls = 1;
    for (int i = 0; i < nacc; i++) begin
      if (lat[i] < 0) begin
        exp_stalls += TO;
        break;
      end
      exp_stalls += lat[i] + 1;
    end

    // Idle cycle with a stray response that must be ignored.
    @(negedge clk);
    valid = 1'b0; read_memory = 1'b0; write_memory = 1'b0;
    dmem_resp = 1'($urandom); dmem_rdata = 16'($urandom);
    #1;
    check_eq("idle_rvalid", rdata_valid, 1'b0);
    check_eq("idle_strobes", {dmem_read, dmem_write}, 2'b00);
    check_eq("idle_stall", stall, 1'b0);
    check_eq("idle_err", mem_error, err_exp);

    @(negedge clk);
    dmem_resp = 1'b0;
    valid = 1'b1; opcode = op; addr = a; wdata = w;
    read_memory  = is_rd;
    write_memory = !is_rd;
    byte_op      = (op == LDB) || (op == STB);
    #1;
    check_eq("req_stall", stall, 1'b1);
    stalls = 1;

    k = 0; c = 0; timed_out = 1'b0; done = 1'b0;
    for (int it = 0; it < 40 && !done; it++) begin
      @(negedge clk);
      valid = 1'b0; read_memory = 1'b0; write_memory = 1'b0; dmem_resp = 1'b0;
      if (k < nacc && lat[k] < 0 && c == TO) begin
        timed_out = 1'b1;
        k = nacc;
      end
      if (k < nacc) begin
        dmem_resp  = (c == lat[k]);
        dmem_rdata = (dmem_resp && !ew[k]) ? mem[ea[k][15:1]] : 16'($urandom);
        #1;
        stalls += int'(stall);
        check_eq("acc_stall", stall, 1'b1);
        check_eq("acc_read", dmem_read, !ew[k]);
        check_eq("acc_write", dmem_write, ew[k]);
        check_eq("acc_addr", dmem_address, ea[k]);
        if (ew[k]) begin
          check_eq("acc_be", dmem_byte_enable, ebe[k]);
          check_eq("acc_wdata", dmem_wdata, ewd[k]);
        end
        if (dmem_resp) begin
          if (ew[k]) begin
            old = mem[ea[k][15:1]];
            mem[ea[k][15:1]] = {ebe[k][1] ? ewd[k][15:8] : old[15:8],
                                ebe[k][0] ? ewd[k][7:0]  : old[7:0]};
          end
          k++;
          c = 0;
        end else begin
          c++;
        end
      end else begin
        dmem_resp  = 1'($urandom);
        dmem_rdata = 16'($urandom);
        #1;
        done = 1'b1;
        if (timed_out) begin
          err_exp    = 1'b1;
          last_rdata = 16'h0000;
        end else if (is_rd) begin
          last_rdata = res;
        end
        check_eq("done_stall", stall, 1'b0);
        check_eq("done_strobes", {dmem_read, dmem_write}, 2'b00);
        check_eq("done_rvalid", rdata_valid, is_rd);
        check_eq("done_rdata", rdata, last_rdata);
        check_eq("done_err", mem_error, err_exp);
        check_eq("stall_cycles", stalls, exp_stalls);
      end
    end
    if (!done) check_eq("txn_bound", 1'b0, 1'b1);
    @(negedge clk);
    dmem_resp = 1'b0;
    $display("txn op=%h addr=%h wdata=%h lat=%0d/%0d rdata=%h err=%0d",
             op, a, w, lat0, lat1, rdata, mem_error);
  endtask

  task automatic reset_mid_access();
    @(negedge clk);
    valid = 1'b1; opcode = LDR; addr = 16'h1234; read_memory = 1'b1;
    write_memory = 1'b0; byte_op = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rst_pre_read", dmem_read, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_read", dmem_read, 1'b0);
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_err", mem_error, 1'b0);
    check_eq("rst_rdata", rdata, 16'h0);
    @(negedge clk);
    valid = 1'b0; read_memory = 1'b0;
    rst_n = 1'b1;
    last_rdata = 16'h0;
    err_exp    = 1'b0;
    @(negedge clk);
    #1;
    check_eq("post_rst_rvalid", rdata_valid, 1'b0);
    check_eq("post_rst_read", dmem_read, 1'b0);
    check_eq("post_rst_stall", stall, 1'b0);
    $display("txn reset during LDR access, rdata=%h err=%0d", rdata, mem_error);
  endtask

  initial begin
    logic [3:0] ops [6];
    ops = '{LDR, STR, LDB, STB, LDI, STI};
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);

    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_strobes", {dmem_read, dmem_write, stall, rdata_valid, mem_error}, 5'b0);
    check_eq("reset_addr", dmem_address, 16'h0);
    check_eq("reset_wdata", dmem_wdata, 16'h0);
    check_eq("reset_be", dmem_byte_enable, 2'b00);
    check_eq("reset_rdata", rdata, 16'h0);
    rst_n = 1'b1;

    mem[16'h3006 >> 1] = 16'hBEEF;
    run_txn(LDR, 16'h3006, 16'h0000, 0, 0);
    check_eq("t1_rdata", rdata, 16'hBEEF);
    run_txn(STB, 16'h4001, 16'h12A5, 2, 0);
    mem[16'h2000 >> 1] = 16'h5003;
    mem[16'h5002 >> 1] = 16'h00C3;
    run_txn(LDI, 16'h2000, 16'h0000, 0, 0);
    check_eq("t3_rdata", rdata, 16'h00C3);
    mem[16'h2002 >> 1] = 16'h6000;
    run_txn(STI, 16'h2002, 16'h7777, 1, 1);
    check_eq("t4_mem", mem[16'h6000 >> 1], 16'h7777);

    for (int n = 0; n < 60; n++) begin
      run_txn(ops[$urandom_range(0, 5)], 16'($urandom), 16'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    run_txn(LDB, 16'h0101, 16'h0000, -1, 0);
    run_txn(LDI, 16'h0200, 16'h0000, 1, -1);
    for (int n = 0; n < 3; n++) begin
      run_txn(ops[$urandom_range(0, 5)], 16'($urandom), 16'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    reset_mid_access();
    run_txn(LDR, 16'h3006, 16'h0000, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage sequencer for the LC-3b pipeline. It consumes the memory-related fields of the decoded control word (read_memory, write_memory, opcode, byte selects) and drives the data-memory/cache request-response interface.
- Handles single-access LDR/STR/LDB/STB and the two-access indirect LDI/STI sequences. Stalls the pipeline until the access completes.
- Sits between the EX/MEM pipeline register and the data cache. Its rdata output feeds the MEM/WB register.

Parameters:
- WORD_WIDTH, 16, data and address width (LC-3b word).
- RESP_TIMEOUT, 0, cycles to wait for dmem_resp before flagging mem_error; 0 disables the timeout.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid  input  1  EX/MEM register holds a live instruction.
- opcode  input  4  lc3b_opcode from the control word.
- read_memory  input  1  control word read request.
- write_memory  input  1  control word write request.
- byte_op  input  1  1 for LDB/STB (ldb_mux_sel or mem_wdata_b_sel).
- addr  input  16  effective address from ALU/address adder.
- wdata  input  16  store data (SR).
- dmem_resp  input  1  cache access complete.
- dmem_rdata  input  16  cache read data.
- dmem_read  output  1  cache read strobe.
- dmem_write  output  1  cache write strobe.
- dmem_address  output  16  cache address, bit 0 forced to 0.
- dmem_wdata  output  16  cache write data.
- dmem_byte_enable  output  2  write byte mask.
- stall  output  1  freeze IF..MEM.
- rdata  output  16  load result to MEM/WB.
- rdata_valid  output  1  one-cycle pulse; rdata is valid.
- mem_error  output  1  sticky timeout flag.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. dmem_read, dmem_write, stall, rdata_valid and mem_error are 0. rdata, dmem_address and dmem_wdata are 0. dmem_byte_enable is 2'b00. Asserting reset mid-access drops strobes immediately, and the in-flight access is abandoned.
- Request detection: req = valid & (read_memory | write_memory). If both strobes are set, read takes priority; this is an illegal encoding, and the assertion bench flags it.
- Indirection is decided by opcode: op_ldi (4'b1010) and op_sti (4'b1011) are indirect.
- IDLE:
  - stall = req, combinationally, in the same cycle.
  - On req: latch opcode, addr, wdata, byte_op and the kind (read/write), then go to ACC1.
  - No request: stay in IDLE, with all strobes 0.
- ACC1:
  - dmem_address = {addr_q[15:1],0}.
  - Read kinds (LDR, LDB, LDI, STI): dmem_read=1.
  - STR: dmem_write=1, byte_enable=2'b11, dmem_wdata=wdata_q.
  - STB: dmem_write=1, dmem_wdata={wdata_q[7:0],wdata_q[7:0]}, byte_enable = addr_q[0] ? 2'b10 : 2'b01.
  - stall=1.
  - On dmem_resp: if the access is indirect, latch dmem_rdata as ind_addr and go to ACC2. Otherwise latch the result into rdata_q and go to DONE.
- ACC2 (LDI/STI only):
  - dmem_address = {ind_addr[15:1],0}.
  - LDI: dmem_read=1.
  - STI: dmem_write=1, byte_enable=2'b11, dmem_wdata=wdata_q.
  - stall=1. On dmem_resp: latch rdata (LDI) and go to DONE.
- DONE: stall=0 and all strobes are 0. rdata_valid=1 for read kinds, 0 for stores. Return to IDLE unconditionally; inputs are not sampled in DONE, so the same instruction cannot re-trigger.
- Load data formation:
  - Word loads: rdata = dmem_rdata.
  - LDB: rdata = {8'h00, addr_q[0] ? dmem_rdata[15:8] : dmem_rdata[7:0]}, zero-extended.
- Timing: a cache hit on the first ACC cycle gives 2 stall cycles for a single access and 3 for an indirect access. The strobes stay high continuously until dmem_resp; they are deasserted in the cycle after resp.
- A dmem_resp arriving in IDLE or DONE is ignored.
- Timeout (RESP_TIMEOUT>0):
  - The counter resets on entry to ACC1/ACC2 and increments each cycle without resp.
  - At RESP_TIMEOUT, set mem_error (sticky until reset) and go to DONE with rdata=16'h0000.
- valid falling while in ACC1/ACC2 has no effect. The pipeline is stalled, so this only occurs on a flush, and flush is not supported here.

Decomposition:
- lc3b_types package:
  - Add the mem_state_t enum {IDLE, ACC1, ACC2, DONE}.
  - Add the constants BE_WORD=2'b11, BE_LO=2'b01, BE_HI=2'b10.
  - Reuse lc3b_opcode and lc3b_word.
- One natural sub-module, mem_byte_lane: the combinational byte extract for LDB and the byte replicate/mask for STB, shared by both states.

Test Plan:
1. LDR, addr=16'h3006, resp on the first ACC1 cycle with rdata=16'hBEEF -> dmem_address=16'h3006, stall high for 2 cycles, rdata=16'hBEEF with a 1-cycle rdata_valid.
2. STB, addr=16'h4001, wdata=16'h12A5, resp after 3 cycles -> dmem_write held 3 cycles, dmem_address=16'h4000, dmem_wdata=16'hA5A5, byte_enable=2'b10, no rdata_valid.
3. LDI, addr=16'h2000; first resp returns 16'h5003, second resp returns 16'h00C3 -> ACC2 address=16'h5002, rdata=16'h00C3, 3 stall cycles.
4. STI, addr=16'h2002, pointer 16'h6000, wdata=16'h7777 -> read at 16'h2002, then write at 16'h6000 with byte_enable=2'b11 and dmem_wdata=16'h7777.
5. rst_n pulled low in ACC1 of an LDR -> dmem_read=0 and stall=0 asynchronously; after release, IDLE with no rdata_valid.
6. RESP_TIMEOUT=4, LDB with no resp -> mem_error set after 4 cycles, DONE with rdata=16'h0000, mem_error stays 1 until reset.
